// File: rtl/mesi_coherence_monitor.sv
// mesi_coherence_monitor: watches per-CPU, per-line MESI states and the CPU
// instruction streams. It flags single-writer/multi-reader breaks, illegal
// encodings, dirty lines right after reset, slow writes and out-of-range
// addresses. Results are a registered pulse, a sticky flag, first-error
// capture and a saturating count.
// Optional feature: define MESI_ISC_MON_COVER_EN to add the cov_seen_o
// per-CPU state-coverage output.

`ifndef MESI_ISC_TB_CPU_MESI_M
`define MESI_ISC_TB_CPU_MESI_M 4'b1001
`endif
`ifndef MESI_ISC_TB_CPU_MESI_E
`define MESI_ISC_TB_CPU_MESI_E 4'b0101
`endif
`ifndef MESI_ISC_TB_CPU_MESI_S
`define MESI_ISC_TB_CPU_MESI_S 4'b0011
`endif
`ifndef MESI_ISC_TB_CPU_MESI_I
`define MESI_ISC_TB_CPU_MESI_I 4'b0000
`endif
`ifndef MESI_ISC_TB_INS_NOP
`define MESI_ISC_TB_INS_NOP 4'd0
`endif
`ifndef MESI_ISC_TB_INS_WR
`define MESI_ISC_TB_INS_WR 4'd1
`endif
`ifndef MESI_ISC_TB_INS_RD
`define MESI_ISC_TB_INS_RD 4'd2
`endif

module mesi_coherence_monitor #(
  parameter int CPU_COUNT  = 4,
  parameter int LINE_COUNT = 10,
  parameter int ADDR_W     = 4,
  parameter int STATE_W    = 4,
  parameter int WR_TIMEOUT = 500,
  parameter int CNT_W      = 16,
  localparam int CPU_W     = (CPU_COUNT > 1) ? $clog2(CPU_COUNT) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [CPU_COUNT*LINE_COUNT*STATE_W-1:0] cache_state_i,
  input  logic [CPU_COUNT*4-1:0]                  ins_i,
  input  logic [CPU_COUNT*ADDR_W-1:0]             ins_addr_i,
  input  logic [CPU_COUNT-1:0]                    ins_ack_i,
  input  logic                                    clr_i,
  output logic                                    viol_o,
  output logic                                    err_o,
  output logic [2:0]                              err_code_o,
  output logic [CPU_W-1:0]                        err_cpu_o,
  output logic [ADDR_W-1:0]                       err_line_o,
  output logic [CNT_W-1:0]                        err_count_o
`ifdef MESI_ISC_MON_COVER_EN
  ,
  output logic [CPU_COUNT*4-1:0]                  cov_seen_o
`endif
);

  localparam int TO_W  = (WR_TIMEOUT > 0) ? $clog2(WR_TIMEOUT + 1) : 1;
  localparam int KEY_W = 3 + ADDR_W + CPU_W;
  localparam logic [STATE_W-1:0] ST_M = STATE_W'(`MESI_ISC_TB_CPU_MESI_M);
  localparam logic [STATE_W-1:0] ST_E = STATE_W'(`MESI_ISC_TB_CPU_MESI_E);
  localparam logic [STATE_W-1:0] ST_S = STATE_W'(`MESI_ISC_TB_CPU_MESI_S);
  localparam logic [STATE_W-1:0] ST_I = STATE_W'(`MESI_ISC_TB_CPU_MESI_I);
  localparam logic [3:0] INS_WR = 4'(`MESI_ISC_TB_INS_WR);
  localparam logic [3:0] INS_RD = 4'(`MESI_ISC_TB_INS_RD);

  typedef enum logic {T_IDLE, T_WAIT} trk_t;

  // Packed views line up with the flat buses: [c][l] sits at (c*LINE_COUNT+l)*STATE_W
  logic [CPU_COUNT-1:0][LINE_COUNT-1:0][STATE_W-1:0] st;
  logic [CPU_COUNT-1:0][3:0]                         ins;
  logic [CPU_COUNT-1:0][ADDR_W-1:0]                  addr;
  assign st   = cache_state_i;
  assign ins  = ins_i;
  assign addr = ins_addr_i;

  logic rst_q, first;
  logic [CPU_COUNT-1:0][LINE_COUNT-1:0] is_m, is_me, is_ni, is_bad;
  logic [CPU_COUNT-1:0] in_range, wr_ok, addr_bad, line_m, to_hit;
  trk_t              trk_q   [CPU_COUNT];
  trk_t              trk_d   [CPU_COUNT];
  logic [ADDR_W-1:0] tline_q [CPU_COUNT];
  logic [ADDR_W-1:0] tline_d [CPU_COUNT];
  logic [TO_W-1:0]   tcnt_q  [CPU_COUNT];
  logic [TO_W-1:0]   tcnt_d  [CPU_COUNT];
  logic [KEY_W-1:0]  best;
  logic              found;

  // Remember reset so the first live cycle after it can be checked for dirty lines
  always_ff @(posedge clk) rst_q <= rst;
  assign first = rst_q & ~rst;

  // Classify every line state once for all checks
  always_comb begin
    for (int c = 0; c < CPU_COUNT; c++)
      for (int l = 0; l < LINE_COUNT; l++) begin
        is_m[c][l]   = st[c][l] == ST_M;
        is_me[c][l]  = is_m[c][l] || st[c][l] == ST_E;
        is_ni[c][l]  = st[c][l] != ST_I;
        is_bad[c][l] = !(is_me[c][l] || st[c][l] == ST_S || st[c][l] == ST_I);
      end
  end

  // Decode accepted instructions and whether each tracked line has reached M
  always_comb begin
    for (int c = 0; c < CPU_COUNT; c++) begin
      in_range[c] = 33'(addr[c]) < 33'(LINE_COUNT);
      wr_ok[c]    = ins_ack_i[c] && ins[c] == INS_WR && in_range[c];
      addr_bad[c] = ins_ack_i[c] && (ins[c] == INS_WR || ins[c] == INS_RD) && !in_range[c];
      line_m[c]   = 1'b0;
      for (int l = 0; l < LINE_COUNT; l++)
        if (tline_q[c] == ADDR_W'(l) && is_m[c][l]) line_m[c] = 1'b1;
    end
  end

  // Write tracker state register
  always_ff @(posedge clk) begin
    for (int c = 0; c < CPU_COUNT; c++) begin
      if (rst) begin
        trk_q[c]   <= T_IDLE;
        tline_q[c] <= '0;
        tcnt_q[c]  <= '0;
      end else begin
        trk_q[c]   <= trk_d[c];
        tline_q[c] <= tline_d[c];
        tcnt_q[c]  <= tcnt_d[c];
      end
    end
  end

  // Write tracker next state: a fresh in-range WR always restarts the wait
  always_comb begin
    for (int c = 0; c < CPU_COUNT; c++) begin
      trk_d[c]   = trk_q[c];
      tline_d[c] = tline_q[c];
      tcnt_d[c]  = tcnt_q[c];
      if (wr_ok[c]) begin
        trk_d[c]   = T_WAIT;
        tline_d[c] = addr[c];
        tcnt_d[c]  = '0;
      end else if (trk_q[c] == T_WAIT) begin
        if (line_m[c] || to_hit[c]) trk_d[c] = T_IDLE;
        else                        tcnt_d[c] = tcnt_q[c] + 1'b1;
      end
    end
  end

  // Write tracker output: timeout when the budget is spent without M; a
  // restarting WR supersedes the old write, so it cannot time out
  always_comb begin
    for (int c = 0; c < CPU_COUNT; c++)
      to_hit[c] = trk_q[c] == T_WAIT && !line_m[c] && !wr_ok[c] &&
                  tcnt_q[c] == TO_W'(WR_TIMEOUT);
  end

  // Gather every violation as a {code,line,cpu} key; the smallest key is the
  // one captured, which gives code, then line, then CPU priority
  always_comb begin : pick
    logic [KEY_W-1:0] key;
    logic             bad_l;
    int               n_me, n_ni;
    logic [CPU_W-1:0] me_cpu;
    best   = '1;
    key    = '1;
    bad_l  = 1'b0;
    n_me   = 0;
    n_ni   = 0;
    me_cpu = '0;
    for (int l = 0; l < LINE_COUNT; l++) begin
      bad_l  = 1'b0;
      n_me   = 0;
      n_ni   = 0;
      me_cpu = '0;
      for (int c = CPU_COUNT - 1; c >= 0; c--) begin
        if (is_bad[c][l]) begin
          bad_l = 1'b1;
          key   = {3'd2, ADDR_W'(l), CPU_W'(c)};
          if (key < best) best = key;
        end
        if (is_me[c][l]) begin
          n_me   = n_me + 1;
          me_cpu = CPU_W'(c);
        end
        if (is_ni[c][l]) n_ni = n_ni + 1;
        if (first && is_ni[c][l]) begin
          key = {3'd3, ADDR_W'(l), CPU_W'(c)};
          if (key < best) best = key;
        end
      end
      // The M/E holder is itself non-I, so a second non-I CPU breaks exclusivity
      if (!bad_l && n_me > 0 && n_ni > 1) begin
        key = {3'd1, ADDR_W'(l), me_cpu};
        if (key < best) best = key;
      end
    end
    for (int c = 0; c < CPU_COUNT; c++) begin
      if (to_hit[c]) begin
        key = {3'd4, tline_q[c], CPU_W'(c)};
        if (key < best) best = key;
      end
      if (addr_bad[c]) begin
        key = {3'd5, addr[c], CPU_W'(c)};
        if (key < best) best = key;
      end
    end
    // Code field never exceeds 5, so all-ones means nothing was found
    found = !rst && best != '1;
  end

  // Report registers: clear wins over old state but a same-cycle violation is still captured
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      err_cpu_o   <= '0;
      err_line_o  <= '0;
      err_count_o <= '0;
    end else begin
      viol_o <= found;
      if (clr_i) begin
        err_o       <= found;
        err_code_o  <= found ? best[KEY_W-1 -: 3]    : '0;
        err_line_o  <= found ? best[CPU_W +: ADDR_W] : '0;
        err_cpu_o   <= found ? best[CPU_W-1:0]       : '0;
        err_count_o <= found ? CNT_W'(1)             : '0;
      end else if (found) begin
        err_o <= 1'b1;
        if (!err_o) begin
          err_code_o <= best[KEY_W-1 -: 3];
          err_line_o <= best[CPU_W +: ADDR_W];
          err_cpu_o  <= best[CPU_W-1:0];
        end
        if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
      end
    end
  end

`ifdef MESI_ISC_MON_COVER_EN
  logic [CPU_COUNT*4-1:0] seen;

  // Which states each CPU holds on any line this cycle
  always_comb begin
    seen = '0;
    for (int c = 0; c < CPU_COUNT; c++)
      for (int l = 0; l < LINE_COUNT; l++) begin
        if (st[c][l] == ST_M) seen[c*4+0] = 1'b1;
        if (st[c][l] == ST_E) seen[c*4+1] = 1'b1;
        if (st[c][l] == ST_S) seen[c*4+2] = 1'b1;
        if (st[c][l] == ST_I) seen[c*4+3] = 1'b1;
      end
  end

  // Sticky coverage bits, cleared then re-seeded on clr_i
  always_ff @(posedge clk) begin
    if (rst) cov_seen_o <= '0;
    else     cov_seen_o <= (clr_i ? '0 : cov_seen_o) | seen;
  end
`endif

endmodule

// File: tb/tb_mesi_coherence_monitor.sv
// Directed bench for mesi_coherence_monitor: a cycle-indexed rule model
// predicts every output each cycle; hand-computed checks pin key scenarios.

`ifndef MESI_ISC_TB_CPU_MESI_M
`define MESI_ISC_TB_CPU_MESI_M 4'b1001
`endif
`ifndef MESI_ISC_TB_CPU_MESI_E
`define MESI_ISC_TB_CPU_MESI_E 4'b0101
`endif
`ifndef MESI_ISC_TB_CPU_MESI_S
`define MESI_ISC_TB_CPU_MESI_S 4'b0011
`endif
`ifndef MESI_ISC_TB_CPU_MESI_I
`define MESI_ISC_TB_CPU_MESI_I 4'b0000
`endif
`ifndef MESI_ISC_TB_INS_NOP
`define MESI_ISC_TB_INS_NOP 4'd0
`endif
`ifndef MESI_ISC_TB_INS_WR
`define MESI_ISC_TB_INS_WR 4'd1
`endif
`ifndef MESI_ISC_TB_INS_RD
`define MESI_ISC_TB_INS_RD 4'd2
`endif

module tb_mesi_coherence_monitor;
  localparam int NC = 4, NL = 10, AW = 4, SW = 4, TO = 500;
  localparam logic [3:0] M = `MESI_ISC_TB_CPU_MESI_M;
  localparam logic [3:0] E = `MESI_ISC_TB_CPU_MESI_E;
  localparam logic [3:0] S = `MESI_ISC_TB_CPU_MESI_S;
  localparam logic [3:0] I = `MESI_ISC_TB_CPU_MESI_I;
  localparam logic [3:0] NOP = `MESI_ISC_TB_INS_NOP;
  localparam logic [3:0] WR  = `MESI_ISC_TB_INS_WR;
  localparam logic [3:0] RD  = `MESI_ISC_TB_INS_RD;
  localparam int NOKEY = 1 << 30;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [3:0]    st   [NC][NL];
  logic [3:0]    ins  [NC];
  logic [AW-1:0] addr [NC];
  logic [NC-1:0] ack;
  logic [NC*NL*SW-1:0] cache_state;
  logic [NC*4-1:0]     ins_bus;
  logic [NC*AW-1:0]    addr_bus;

  logic        viol, err, viol2, err2;
  logic [2:0]  code, code2;
  logic [1:0]  cpu, cpu2;
  logic [3:0]  line, line2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
`ifdef MESI_ISC_MON_COVER_EN
  logic [NC*4-1:0] cov, cov2;
  logic [NC*4-1:0] e_cov;
`endif

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    cache_state = '0;
    ins_bus     = '0;
    addr_bus    = '0;
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < NL; l++) cache_state[(c*NL+l)*SW +: SW] = st[c][l];
      ins_bus[c*4 +: 4]    = ins[c];
      addr_bus[c*AW +: AW] = addr[c];
    end
  end

  mesi_coherence_monitor #(.CPU_COUNT(NC), .LINE_COUNT(NL), .ADDR_W(AW), .STATE_W(SW),
                           .WR_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cache_state_i(cache_state), .ins_i(ins_bus),
    .ins_addr_i(addr_bus), .ins_ack_i(ack), .clr_i(clr), .viol_o(viol), .err_o(err),
    .err_code_o(code), .err_cpu_o(cpu), .err_line_o(line), .err_count_o(cnt)
`ifdef MESI_ISC_MON_COVER_EN
    , .cov_seen_o(cov)
`endif
  );

  mesi_coherence_monitor #(.CPU_COUNT(NC), .LINE_COUNT(NL), .ADDR_W(AW), .STATE_W(SW),
                           .WR_TIMEOUT(TO), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cache_state_i(cache_state), .ins_i(ins_bus),
    .ins_addr_i(addr_bus), .ins_ack_i(ack), .clr_i(clr), .viol_o(viol2), .err_o(err2),
    .err_code_o(code2), .err_cpu_o(cpu2), .err_line_o(line2), .err_count_o(cnt2)
`ifdef MESI_ISC_MON_COVER_EN
    , .cov_seen_o(cov2)
`endif
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", n, a, e, $time);
    end
  endtask

  function automatic int mk(input int cd, input int ln, input int c);
    return cd * 4096 + ln * 64 + c;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- rule model ----------------
  int cyc = 0;
  bit rst_prev = 1'b1;
  bit e_viol, e_err;
  int e_code, e_cpu, e_line, e_cnt;
  bit pend [NC];
  int acc  [NC];
  int pl   [NC];

  always @(posedge clk) begin
    int best, nme, nni, fme;
    bit bad, first, any, legal;
    cyc++;
    first = rst_prev && !rst;
    if (rst) begin
      e_viol = 0; e_err = 0; e_code = 0; e_cpu = 0; e_line = 0; e_cnt = 0;
      for (int c = 0; c < NC; c++) pend[c] = 0;
`ifdef MESI_ISC_MON_COVER_EN
      e_cov = '0;
`endif
    end else begin
      best = NOKEY;
      for (int l = 0; l < NL; l++) begin
        bad = 0; nme = 0; nni = 0; fme = -1;
        for (int c = 0; c < NC; c++) begin
          legal = st[c][l] == M || st[c][l] == E || st[c][l] == S || st[c][l] == I;
          if (!legal) begin bad = 1; best = imin(best, mk(2, l, c)); end
          if (st[c][l] == M || st[c][l] == E) begin nme++; if (fme < 0) fme = c; end
          if (st[c][l] != I) begin
            nni++;
            if (first) best = imin(best, mk(3, l, c));
          end
        end
        if (!bad && nme > 0 && nni > 1) best = imin(best, mk(1, l, fme));
      end
      for (int c = 0; c < NC; c++) begin
        if (ack[c] && (ins[c] == WR || ins[c] == RD) && int'(addr[c]) >= NL)
          best = imin(best, mk(5, int'(addr[c]), c));
        if (ack[c] && ins[c] == WR && int'(addr[c]) < NL) begin
          pend[c] = 1; acc[c] = cyc; pl[c] = int'(addr[c]);
        end else if (pend[c]) begin
          if (st[c][pl[c]] == M) pend[c] = 0;
          else if (cyc - acc[c] == TO + 1) begin
            best = imin(best, mk(4, pl[c], c));
            pend[c] = 0;
          end
        end
      end
      any = best != NOKEY;
      e_viol = any;
      if (clr) begin
        e_err = any; e_cnt = any ? 1 : 0;
        e_code = any ? best / 4096 : 0;
        e_line = any ? (best / 64) % 64 : 0;
        e_cpu  = any ? best % 64 : 0;
      end else if (any) begin
        if (!e_err) begin
          e_code = best / 4096; e_line = (best / 64) % 64; e_cpu = best % 64;
        end
        e_err = 1;
        e_cnt++;
      end
`ifdef MESI_ISC_MON_COVER_EN
      if (clr) e_cov = '0;
      for (int c = 0; c < NC; c++)
        for (int l = 0; l < NL; l++) begin
          if (st[c][l] == M) e_cov[c*4+0] = 1'b1;
          if (st[c][l] == E) e_cov[c*4+1] = 1'b1;
          if (st[c][l] == S) e_cov[c*4+2] = 1'b1;
          if (st[c][l] == I) e_cov[c*4+3] = 1'b1;
        end
`endif
    end
    rst_prev = rst;
    #2;
    chk("viol", viol, e_viol);
    chk("err", err, e_err);
    chk("code", code, e_code);
    chk("cpu", cpu, e_cpu);
    chk("line", line, e_line);
    chk("count", cnt, (e_cnt > 65535) ? 65535 : e_cnt);
    chk("viol_c2", viol2, e_viol);
    chk("err_c2", err2, e_err);
    chk("code_c2", code2, e_code);
    chk("cpu_c2", cpu2, e_cpu);
    chk("line_c2", line2, e_line);
    chk("count_c2", cnt2, (e_cnt > 3) ? 3 : e_cnt);
`ifdef MESI_ISC_MON_COVER_EN
    chk("cov", cov, e_cov);
    chk("cov_c2", cov2, e_cov);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int c, input int a, input logic [3:0] op);
    ins[c] = op; addr[c] = AW'(a); ack[c] = 1'b1;
    tick(1);
    ins[c] = NOP; ack[c] = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int c = 0; c < NC; c++) begin
      ins[c] = NOP; addr[c] = '0;
      for (int l = 0; l < NL; l++) st[c][l] = I;
    end
    ack = '0;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(100);
    chk("idle_err", err, 0);
    chk("idle_count", cnt, 0);

    // cpu0 M + cpu2 S on line 3
    st[0][3] = M; st[2][3] = S;
    tick(1);
    chk("excl_viol", viol, 1);
    chk("excl_code", code, 1);
    chk("excl_cpu", cpu, 0);
    chk("excl_line", line, 3);
    chk("excl_count", cnt, 1);
    st[0][3] = I; st[2][3] = I;
    tick(1);
    chk("excl_pulse_end", viol, 0);
    pulse_clr();
    chk("clr_err", err, 0);
    chk("clr_code", code, 0);
    chk("clr_count", cnt, 0);

    // write reaching M 499 cycles after accept
    issue(1, 7, WR);
    tick(498);
    st[1][7] = M;
    tick(1);
    st[1][7] = I;
    tick(3);
    chk("wr_ok_err", err, 0);

    // write never reaching M
    issue(1, 7, WR);
    k = 0;
    while (viol !== 1'b1 && k < 600) begin
      tick(1);
      k++;
    end
    chk("wr_to_latency", k, 501);
    chk("wr_to_code", code, 4);
    chk("wr_to_cpu", cpu, 1);
    chk("wr_to_line", line, 7);
    pulse_clr();

    // M in the very last allowed cycle
    issue(0, 2, WR);
    tick(500);
    st[0][2] = M;
    tick(1);
    st[0][2] = I;
    tick(3);
    chk("wr_edge_err", err, 0);

    // zero-wait completion on the top in-range line
    issue(0, 9, WR);
    st[0][9] = M;
    tick(1);
    st[0][9] = I;
    tick(505);
    chk("wr_zero_err", err, 0);

    // bad encoding + out-of-range RD in one cycle
    st[3][0] = 4'hF;
    ins[1] = RD; addr[1] = 4'd12; ack[1] = 1'b1;
    tick(1);
    st[3][0] = I; ins[1] = NOP; ack[1] = 1'b0;
    chk("enc_code", code, 2);
    chk("enc_line", line, 0);
    chk("enc_cpu", cpu, 3);
    chk("enc_count", cnt, 1);
    tick(1);
    chk("enc_count_hold", cnt, 1);
    pulse_clr();

    // out-of-range WR leaves tracker idle
    issue(0, 10, WR);
    chk("addr_code", code, 5);
    chk("addr_line", line, 10);
    chk("addr_cpu", cpu, 0);
    tick(510);
    chk("addr_no_to", cnt, 1);
    pulse_clr();

    // five violating cycles: saturation on the narrow counter
    st[1][4] = E; st[3][4] = S;
    tick(5);
    chk("sat_count16", cnt, 5);
    chk("sat_count2", cnt2, 3);
    chk("sat_cpu", cpu, 1);
    // clear with a fresh same-cycle violation (two M on line 6)
    clr = 1'b1;
    st[1][4] = I; st[3][4] = I; st[0][6] = M; st[1][6] = M;
    tick(1);
    clr = 1'b0; st[0][6] = I; st[1][6] = I;
    chk("clrv_err", err, 1);
    chk("clrv_count", cnt, 1);
    chk("clrv_count2", cnt2, 1);
    chk("clrv_line", line, 6);
    chk("clrv_cpu", cpu, 0);
    tick(1);
    chk("clrv_viol_end", viol, 0);

    // dirty line right after reset
    rst = 1'b1; st[2][5] = S;
    tick(3);
    rst = 1'b0;
    tick(1);
    st[2][5] = I;
    chk("rst_viol", viol, 1);
    chk("rst_code", code, 3);
    chk("rst_cpu", cpu, 2);
    chk("rst_line", line, 5);

    // reset during a pending write abandons it
    pulse_clr();
    issue(2, 1, WR);
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(600);
    chk("rst_wait_err", err, 0);

`ifdef MESI_ISC_MON_COVER_EN
    pulse_clr();
    st[2][3] = E; tick(1);
    st[2][3] = M; tick(1);
    st[2][3] = I; tick(2);
    begin
      logic [15:0] cv;
      cv = cov;
      chk("cov_cpu2", cv[11:8], 4'b1011);
    end
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
